// File: rtl/dma_pkg.sv
// Register map, field positions and bus/FSM encodings shared by the DMA register front-end.
package dma_pkg;

    localparam logic [4:0] REG_SRC    = 5'h00;
    localparam logic [4:0] REG_DST    = 5'h04;
    localparam logic [4:0] REG_LEN    = 5'h08;
    localparam logic [4:0] REG_CTRL   = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    // Byte offset inside the register window for a word index taken from addr[4:2].
    function automatic logic [4:0] regOffset(input logic [2:0] wordIdx);
        return {wordIdx, 2'b00};
    endfunction

endpackage

// File: rtl/dma_axil_regs.sv
// AXI-lite register file and control front-end of the DMA engine: holds SRC/DST/LEN,
// issues the start pulse and keeps busy/done status for software.
module dma_axil_regs #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,

    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,

    output logic [DATA_W-1:0] c_src_addr,
    output logic [DATA_W-1:0] c_dst_addr,
    output logic [LEN_W-1:0]  c_len,
    output logic              c_start,
    input  logic              c_status_busy,
    input  logic              c_status_done,
    output logic              irq
);
    import dma_pkg::*;

    w_state_e          wState_q, wState_d;
    logic              awHeld_q, awHeld_d;
    logic [ADDR_W-3:0] awAddr_q, awAddr_d;
    logic              wHeld_q, wHeld_d;
    logic [DATA_W-1:0] wData_q, wData_d;
    axi_resp_e         bResp_q, bResp_d;
    logic              commit;

    r_state_e          rState_q, rState_d;
    logic [DATA_W-1:0] rData_q, rData_d;
    axi_resp_e         rResp_q, rResp_d;
    logic [DATA_W-1:0] rdValue;
    logic              rdHit;

    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ie_q, ie_d;
    logic              doneSticky_q, doneSticky_d;
    logic              start_q, start_d;

    logic              unusedAddrBits;

    // A word address hits a register when it lies in 0x00..0x10 and no upper bit is set.
    function automatic logic regHit(input logic [ADDR_W-3:0] wordAddr);
        return (wordAddr[ADDR_W-3:3] == '0) && (regOffset(wordAddr[2:0]) <= REG_STATUS);
    endfunction

    assign unusedAddrBits = ^{s_awaddr[1:0], s_araddr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q <= W_IDLE;
            awHeld_q <= 1'b0;
            awAddr_q <= '0;
            wHeld_q  <= 1'b0;
            wData_q  <= '0;
            bResp_q  <= OKAY;
        end else begin
            wState_q <= wState_d;
            awHeld_q <= awHeld_d;
            awAddr_q <= awAddr_d;
            wHeld_q  <= wHeld_d;
            wData_q  <= wData_d;
            bResp_q  <= bResp_d;
        end
    end

    // AW and W are latched independently; the write commits on the edge where both are present.
    always_comb begin
        wState_d  = wState_q;
        awHeld_d  = awHeld_q;
        awAddr_d  = awAddr_q;
        wHeld_d   = wHeld_q;
        wData_d   = wData_q;
        bResp_d   = bResp_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        commit    = 1'b0;
        unique case (wState_q)
            W_IDLE: begin
                s_awready = ~rst & ~awHeld_q;
                s_wready  = ~rst & ~wHeld_q;
                if (s_awvalid && s_awready) begin
                    awHeld_d = 1'b1;
                    awAddr_d = s_awaddr[ADDR_W-1:2];
                end
                if (s_wvalid && s_wready) begin
                    wHeld_d = 1'b1;
                    wData_d = s_wdata;
                end
                if (awHeld_d && wHeld_d) begin
                    commit   = 1'b1;
                    awHeld_d = 1'b0;
                    wHeld_d  = 1'b0;
                    wState_d = W_RESP;
                    bResp_d  = regHit(awAddr_d) ? OKAY : SLVERR;
                end
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            ie_q         <= 1'b0;
            doneSticky_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            ie_q         <= ie_d;
            doneSticky_q <= doneSticky_d;
            start_q      <= start_d;
        end
    end

    // A done pulse is applied last so it wins over a same-cycle clear.
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        ie_d         = ie_q;
        doneSticky_d = doneSticky_q;
        start_d      = 1'b0;
        if (commit && regHit(awAddr_d)) begin
            case (regOffset(awAddr_d[2:0]))
                REG_SRC: src_d = wData_d;
                REG_DST: dst_d = wData_d;
                REG_LEN: len_d = wData_d[LEN_W-1:0];
                REG_CTRL: begin
                    ie_d = wData_d[CTRL_IE_BIT];
                    if (wData_d[CTRL_START_BIT] && !c_status_busy) begin
                        start_d      = 1'b1;
                        doneSticky_d = 1'b0;
                    end
                end
                REG_STATUS: begin
                    if (wData_d[STATUS_DONE_BIT]) begin
                        doneSticky_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (c_status_done) begin
            doneSticky_d = 1'b1;
        end
    end

    always_comb begin
        rdValue = '0;
        rdHit   = regHit(s_araddr[ADDR_W-1:2]);
        if (rdHit) begin
            case (regOffset(s_araddr[4:2]))
                REG_SRC:  rdValue = src_q;
                REG_DST:  rdValue = dst_q;
                REG_LEN:  rdValue[LEN_W-1:0] = len_q;
                REG_CTRL: rdValue[CTRL_IE_BIT] = ie_q;
                REG_STATUS: begin
                    rdValue[STATUS_BUSY_BIT] = c_status_busy;
                    rdValue[STATUS_DONE_BIT] = doneSticky_q;
                end
                default: rdValue = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q <= R_IDLE;
            rData_q  <= '0;
            rResp_q  <= OKAY;
        end else begin
            rState_q <= rState_d;
            rData_q  <= rData_d;
            rResp_q  <= rResp_d;
        end
    end

    // Read data is registered from the pre-edge register values, so a colliding write is not seen.
    always_comb begin
        rState_d  = rState_q;
        rData_d   = rData_q;
        rResp_d   = rResp_q;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        unique case (rState_q)
            R_IDLE: begin
                s_arready = ~rst;
                if (s_arvalid && s_arready) begin
                    rState_d = R_RESP;
                    rData_d  = rdValue;
                    rResp_d  = rdHit ? OKAY : SLVERR;
                end
            end
            R_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    rState_d = R_IDLE;
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    assign s_bresp    = bResp_q;
    assign s_rdata    = rData_q;
    assign s_rresp    = rResp_q;
    assign c_src_addr = src_q;
    assign c_dst_addr = dst_q;
    assign c_len      = len_q;
    assign c_start    = start_q;
    assign irq        = doneSticky_q & ie_q;

endmodule

// File: tb/tb_dma_axil_regs.sv
// Directed bench for dma_axil_regs: a transaction-level register model is checked against
// the DUT every cycle, alongside hand-computed expectations for each scenario.
module tb_dma_axil_regs;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr = '0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [DATA_W-1:0] s_wdata = '0;
    logic              s_bvalid;
    logic              s_bready = 1'b1;
    logic [1:0]        s_bresp;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic              s_rvalid;
    logic              s_rready = 1'b1;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic [DATA_W-1:0] c_src_addr;
    logic [DATA_W-1:0] c_dst_addr;
    logic [LEN_W-1:0]  c_len;
    logic              c_start;
    logic              c_status_busy = 1'b0;
    logic              c_status_done = 1'b0;
    logic              irq;

    int total = 0;
    int bad = 0;
    int startCount = 0;

    dma_axil_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .c_src_addr(c_src_addr), .c_dst_addr(c_dst_addr), .c_len(c_len),
        .c_start(c_start), .c_status_busy(c_status_busy), .c_status_done(c_status_done),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Register model: programmer-visible state plus pending-transaction bookkeeping.
    logic [31:0] mSrc = '0, mDst = '0, mAwAddr = '0, mWData = '0, mRdata = '0;
    logic [15:0] mLen = '0;
    logic        mIe = 1'b0, mDone = 1'b0, mStart = 1'b0;
    logic        mAwHeld = 1'b0, mWHeld = 1'b0, mBvalid = 1'b0, mRvalid = 1'b0;
    logic [1:0]  mBresp = 2'b00, mRresp = 2'b00;

    function automatic logic legal(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) <= 32'h10;
    endfunction

    function automatic logic [31:0] readReg(input logic [31:0] a);
        if (!legal(a)) return 32'h0;
        case (a & 32'hFFFF_FFFC)
            32'h00:  return mSrc;
            32'h04:  return mDst;
            32'h08:  return {16'h0, mLen};
            32'h0C:  return mIe ? 32'h2 : 32'h0;
            default: return (c_status_busy ? 32'h1 : 32'h0) | (mDone ? 32'h2 : 32'h0);
        endcase
    endfunction

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        if (!legal(a)) return;
        case (a & 32'hFFFF_FFFC)
            32'h00: mSrc = d;
            32'h04: mDst = d;
            32'h08: mLen = d[15:0];
            32'h0C: begin
                mIe = d[1];
                if (d[0] && !c_status_busy) begin
                    mStart = 1'b1;
                    mDone  = 1'b0;
                end
            end
            default: if (d[1]) mDone = 1'b0;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin : modelStep
        logic awHs, wHs;
        if (rst) begin
            mSrc = '0; mDst = '0; mLen = '0; mIe = 1'b0; mDone = 1'b0; mStart = 1'b0;
            mAwHeld = 1'b0; mWHeld = 1'b0; mBvalid = 1'b0; mRvalid = 1'b0;
            mBresp = 2'b00; mRresp = 2'b00; mRdata = '0;
        end else begin
            mStart = 1'b0;
            if (!mRvalid) begin
                if (s_arvalid) begin
                    mRdata  = readReg(s_araddr);
                    mRresp  = legal(s_araddr) ? 2'b00 : 2'b10;
                    mRvalid = 1'b1;
                end
            end else if (s_rready) begin
                mRvalid = 1'b0;
            end
            if (!mBvalid) begin
                awHs = s_awvalid && !mAwHeld;
                wHs  = s_wvalid && !mWHeld;
                if (awHs) begin mAwHeld = 1'b1; mAwAddr = s_awaddr; end
                if (wHs) begin mWHeld = 1'b1; mWData = s_wdata; end
                if (mAwHeld && mWHeld) begin
                    doWrite(mAwAddr, mWData);
                    mBresp  = legal(mAwAddr) ? 2'b00 : 2'b10;
                    mBvalid = 1'b1;
                    mAwHeld = 1'b0;
                    mWHeld  = 1'b0;
                end
            end else if (s_bready) begin
                mBvalid = 1'b0;
            end
            if (c_status_done) mDone = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (c_start) startCount++;
        checkOutput("awready", 32'(s_awready), 32'(!rst && !mBvalid && !mAwHeld));
        checkOutput("wready",  32'(s_wready),  32'(!rst && !mBvalid && !mWHeld));
        checkOutput("arready", 32'(s_arready), 32'(!rst && !mRvalid));
        checkOutput("bvalid",  32'(s_bvalid),  32'(mBvalid));
        checkOutput("bresp",   32'(s_bresp),   32'(mBresp));
        checkOutput("rvalid",  32'(s_rvalid),  32'(mRvalid));
        checkOutput("rdata",   s_rdata,        mRdata);
        checkOutput("rresp",   32'(s_rresp),   32'(mRresp));
        checkOutput("src",     c_src_addr,     mSrc);
        checkOutput("dst",     c_dst_addr,     mDst);
        checkOutput("len",     32'(c_len),     32'(mLen));
        checkOutput("start",   32'(c_start),   32'(mStart));
        checkOutput("irq",     32'(irq),       32'(mDone && mIe));
    end

    task automatic applyStimulus(input int awv, input logic [31:0] awa, input int wv, input logic [31:0] wd,
                                 input int bre, input int arv, input logic [31:0] ara, input int rre);
        s_awvalid = (awv != 0);
        s_awaddr  = awa;
        s_wvalid  = (wv != 0);
        s_wdata   = wd;
        s_bready  = (bre != 0);
        s_arvalid = (arv != 0);
        s_araddr  = ara;
        s_rready  = (rre != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1);
    endtask

    task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [31:0] expResp);
        applyStimulus(1, a, 1, d, 1, 0, 32'h0, 1);
        checkOutput("wr_bvalid_lat", 32'(s_bvalid), 32'h1);
        checkOutput("wr_bresp_lit", 32'(s_bresp), expResp);
        idle();
    endtask

    task automatic axiRead(input logic [31:0] a, input logic [31:0] expData, input logic [31:0] expResp);
        applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, a, 1);
        checkOutput("rd_rvalid_lat", 32'(s_rvalid), 32'h1);
        checkOutput("rd_rdata_lit", s_rdata, expData);
        checkOutput("rd_rresp_lit", 32'(s_rresp), expResp);
        idle();
    endtask

    initial begin
        int starts;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_awready_low", 32'(s_awready), 32'h0);
        checkOutput("rst_arready_low", 32'(s_arready), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_awready", 32'(s_awready), 32'h1);
        checkOutput("post_rst_wready", 32'(s_wready), 32'h1);
        checkOutput("post_rst_arready", 32'(s_arready), 32'h1);
        checkOutput("post_rst_bvalid", 32'(s_bvalid), 32'h0);
        checkOutput("post_rst_rdata", s_rdata, 32'h0);
        checkOutput("post_rst_len", 32'(c_len), 32'h0);
        checkOutput("post_rst_irq", 32'(irq), 32'h0);

        axiWrite(32'h00, 32'h0, 32'h0);
        axiWrite(32'h04, 32'h6, 32'h0);
        axiWrite(32'h08, 32'h1, 32'h0);
        axiWrite(32'h0C, 32'h1, 32'h0);
        idle();
        checkOutput("prog_src", c_src_addr, 32'h0);
        checkOutput("prog_dst", c_dst_addr, 32'h6);
        checkOutput("prog_len", 32'(c_len), 32'h1);
        checkOutput("single_start", 32'(startCount), 32'h1);
        axiRead(32'h04, 32'h6, 32'h0);
        axiRead(32'h0C, 32'h0, 32'h0);

        applyStimulus(1, 32'h00, 0, 32'h0, 1, 0, 32'h0, 1);
        checkOutput("aw_first_awready", 32'(s_awready), 32'h0);
        checkOutput("aw_first_bvalid", 32'(s_bvalid), 32'h0);
        idle();
        checkOutput("aw_first_bvalid2", 32'(s_bvalid), 32'h0);
        applyStimulus(0, 32'h0, 1, 32'hA5A5_0001, 1, 0, 32'h0, 1);
        checkOutput("aw_first_commit", 32'(s_bvalid), 32'h1);
        checkOutput("aw_first_src", c_src_addr, 32'hA5A5_0001);
        idle();
        applyStimulus(0, 32'h0, 1, 32'h1234_5678, 1, 0, 32'h0, 1);
        checkOutput("w_first_wready", 32'(s_wready), 32'h0);
        checkOutput("w_first_bvalid", 32'(s_bvalid), 32'h0);
        applyStimulus(1, 32'h04, 0, 32'h0, 1, 0, 32'h0, 1);
        checkOutput("w_first_commit", 32'(s_bvalid), 32'h1);
        checkOutput("w_first_dst", c_dst_addr, 32'h1234_5678);
        idle();

        applyStimulus(1, 32'h08, 1, 32'h0003_0007, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_bvalid", 32'(s_bvalid), 32'h1);
            checkOutput("stall_bresp", 32'(s_bresp), 32'h0);
            checkOutput("stall_awready", 32'(s_awready), 32'h0);
            applyStimulus(1, 32'h00, 0, 32'h0, 0, 0, 32'h0, 1);
        end
        checkOutput("stall_bvalid_end", 32'(s_bvalid), 32'h1);
        applyStimulus(1, 32'h00, 0, 32'h0, 1, 0, 32'h0, 1);
        checkOutput("stall_released", 32'(s_bvalid), 32'h0);
        applyStimulus(1, 32'h00, 1, 32'h40, 1, 0, 32'h0, 1);
        checkOutput("stall_next_commit", 32'(s_bvalid), 32'h1);
        idle();
        checkOutput("len_truncated", 32'(c_len), 32'h7);
        checkOutput("pending_src", c_src_addr, 32'h40);
        axiRead(32'h08, 32'h7, 32'h0);

        axiWrite(32'h0C, 32'h2, 32'h0);
        c_status_done = 1'b1;
        idle();
        c_status_done = 1'b0;
        checkOutput("done_irq", 32'(irq), 32'h1);
        axiRead(32'h10, 32'h2, 32'h0);
        axiWrite(32'h10, 32'h2, 32'h0);
        checkOutput("w1c_irq", 32'(irq), 32'h0);
        axiRead(32'h10, 32'h0, 32'h0);

        c_status_busy = 1'b1;
        starts = startCount;
        axiWrite(32'h0C, 32'h1, 32'h0);
        idle();
        checkOutput("busy_no_start", 32'(startCount), 32'(starts));
        axiRead(32'h0C, 32'h0, 32'h0);
        axiRead(32'h10, 32'h1, 32'h0);
        axiWrite(32'h0C, 32'h3, 32'h0);
        idle();
        checkOutput("busy_no_start2", 32'(startCount), 32'(starts));
        axiRead(32'h0C, 32'h2, 32'h0);
        c_status_busy = 1'b0;

        c_status_done = 1'b1;
        idle();
        c_status_done = 1'b1;
        axiWrite(32'h10, 32'h2, 32'h0);
        c_status_done = 1'b0;
        axiRead(32'h10, 32'h2, 32'h0);
        checkOutput("set_wins_irq", 32'(irq), 32'h1);
        axiWrite(32'h0C, 32'h1, 32'h0);
        idle();
        checkOutput("start_counted", 32'(startCount), 32'(starts + 1));
        axiRead(32'h10, 32'h0, 32'h0);
        checkOutput("start_clears_irq", 32'(irq), 32'h0);

        applyStimulus(1, 32'h00, 1, 32'hDEAD_0000, 1, 1, 32'h00, 1);
        checkOutput("collide_rvalid", 32'(s_rvalid), 32'h1);
        checkOutput("collide_old_data", s_rdata, 32'h40);
        checkOutput("collide_bvalid", 32'(s_bvalid), 32'h1);
        idle();
        axiRead(32'h00, 32'hDEAD_0000, 32'h0);

        axiRead(32'h20, 32'h0, 32'h2);
        axiWrite(32'h24, 32'hFFFF_FFFF, 32'h2);
        axiWrite(32'h14, 32'hFFFF_FFFF, 32'h2);
        checkOutput("err_src_kept", c_src_addr, 32'hDEAD_0000);
        checkOutput("err_dst_kept", c_dst_addr, 32'h1234_5678);
        checkOutput("err_len_kept", 32'(c_len), 32'h7);
        axiRead(32'h14, 32'h0, 32'h2);
        axiRead(32'h1000_0000, 32'h0, 32'h2);
        axiRead(32'h13, 32'h0, 32'h0);

        applyStimulus(1, 32'h00, 1, 32'h55, 0, 0, 32'h0, 1);
        checkOutput("pre_rst_bvalid", 32'(s_bvalid), 32'h1);
        rst = 1'b1;
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        s_bready = 1'b1;
        #1;
        checkOutput("mid_rst_bvalid", 32'(s_bvalid), 32'h0);
        checkOutput("mid_rst_awready", 32'(s_awready), 32'h0);
        checkOutput("mid_rst_src", c_src_addr, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("rerst_awready", 32'(s_awready), 32'h1);
        checkOutput("rerst_bvalid", 32'(s_bvalid), 32'h0);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
